// File: rtl/sump_cmd_parser.sv
// SUMP/OLS byte command parser: assembles short (1-byte) and long (opcode + 4 argument bytes)
// commands, tracks XON/XOFF and detects the 0x00 soft-reset sequence. Optional macro: CMD_TIMEOUT_EN.
module sump_cmd_parser #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter int          RST_REPEAT     = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  data_i,
  input  logic        stb_i,
  output logic [7:0]  opc_o,
  output logic [31:0] cmd_o,
  output logic        exec_o,
  output logic        xoff_o,
  output logic        soft_rst_o,
  output logic        timeout_o,
  output logic        busy_o
);

  localparam int ZW = $clog2(RST_REPEAT + 1);

  // Input handshake: data_i is valid only in a cycle with stb_i high; there is no ready,
  // every strobed byte is consumed in that cycle.
  typedef enum logic {IDLE, ARGS} state_e;

  state_e        state_q;
  logic [7:0]    lopc_q;
  logic [1:0]    idx_q;
  logic [31:0]   arg_q;
  logic [31:0]   arg_d;
  logic [ZW-1:0] zero_q;
  logic [7:0]    opc_q;
  logic [31:0]   cmd_q;
  logic          exec_q;
  logic          xoff_q;
  logic          srst_q;
`ifdef CMD_TIMEOUT_EN
  logic [15:0]   tmo_q;
  logic          tmo_pulse_q;
`endif

  always_comb begin
    arg_d = arg_q;
    case (idx_q)
      2'd0:    arg_d[7:0]   = data_i;
      2'd1:    arg_d[15:8]  = data_i;
      2'd2:    arg_d[23:16] = data_i;
      default: arg_d[31:24] = data_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lopc_q      <= '0;
      idx_q       <= '0;
      arg_q       <= '0;
      zero_q      <= '0;
      opc_q       <= '0;
      cmd_q       <= '0;
      exec_q      <= 1'b0;
      xoff_q      <= 1'b0;
      srst_q      <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_q       <= '0;
      tmo_pulse_q <= 1'b0;
`endif
    end else begin
      exec_q <= 1'b0;
      srst_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_pulse_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (stb_i) begin
            if (!data_i[7]) begin
              opc_q  <= data_i;
              cmd_q  <= '0;
              exec_q <= 1'b1;
              if (data_i == 8'h00) begin
                // Soft reset fires on the RST_REPEAT-th zero, then the count restarts.
                if (zero_q == ZW'(RST_REPEAT - 1)) begin
                  zero_q <= '0;
                  srst_q <= 1'b1;
                  xoff_q <= 1'b0;
                end else begin
                  zero_q <= zero_q + ZW'(1);
                end
              end else begin
                zero_q <= '0;
                if (data_i == 8'h13) xoff_q <= 1'b1;
                if (data_i == 8'h11) xoff_q <= 1'b0;
              end
            end else begin
              lopc_q  <= data_i;
              idx_q   <= '0;
              zero_q  <= '0;
              state_q <= ARGS;
`ifdef CMD_TIMEOUT_EN
              tmo_q   <= '0;
`endif
            end
          end
        end
        ARGS: begin
          if (stb_i) begin
            arg_q <= arg_d;
            idx_q <= idx_q + 2'd1;
`ifdef CMD_TIMEOUT_EN
            tmo_q <= '0;
`endif
            if (idx_q == 2'd3) begin
              opc_q   <= lopc_q;
              cmd_q   <= arg_d;
              exec_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
`ifdef CMD_TIMEOUT_EN
          // A strobe in the limit cycle takes priority over the timeout.
          else if (tmo_q == TIMEOUT_CYCLES - 16'd1) begin
            state_q     <= IDLE;
            tmo_pulse_q <= 1'b1;
            tmo_q       <= '0;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign opc_o      = opc_q;
  assign cmd_o      = cmd_q;
  assign exec_o     = exec_q;
  assign xoff_o     = xoff_q;
  assign soft_rst_o = srst_q;
  // busy_o is the FSM state itself (two states), so it doubles as the state debug view.
  assign busy_o     = (state_q == ARGS);
`ifdef CMD_TIMEOUT_EN
  assign timeout_o  = tmo_pulse_q;
`else
  wire [15:0] unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout_o  = 1'b0;
`endif

endmodule
